// File: rtl/seq_unit.sv
// Program sequencer: next-PC selection, LIFO return stack and an edge-triggered,
// non-nesting vectored interrupt controller with sticky stack error flags.
module seq_unit #(
    parameter int              PC_W        = 10,
    parameter int              STACK_DEPTH = 8,
    parameter int              N_INTR      = 8,
    parameter logic [PC_W-1:0] VEC_BASE    = 10'h3F0,
    parameter int              VEC_STRIDE  = 2,
    localparam int             ID_W        = (N_INTR > 1) ? $clog2(N_INTR) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        pc_sel,
    input  logic [PC_W-1:0]   target,
    input  logic              call,
    input  logic              reti,
    input  logic [N_INTR-1:0] intr,
    input  logic [N_INTR-1:0] intr_mask,
    input  logic              intr_en,
    input  logic              clr_err,
    output logic [PC_W-1:0]   pc,
    output logic              stack_full,
    output logic              stack_empty,
    output logic              err_ovf,
    output logic              err_udf,
    output logic              intr_ack,
    output logic [ID_W-1:0]   intr_id,
    output logic              in_service
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]   stack_q [STACK_DEPTH];
    logic [N_INTR-1:0] prev_q, pend_q, pend_d;
    logic              in_svc_q, in_svc_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              ack_q;
    logic              full_q, empty_q;
    logic [ID_W-1:0]   id_q, id_d;

    logic              push_s;
    logic [PC_W-1:0]   push_val_s;
    logic              take_s;
    logic [ID_W-1:0]   take_id_s;
    logic [N_INTR-1:0] elig_s;
    logic [PC_W-1:0]   pc_inc_s, top_s, vec_s;
    logic              is_full_s, is_empty_s;

    assign pc_inc_s   = pc_q + PC_W'(1);
    assign is_full_s  = (sp_q == SP_W'(STACK_DEPTH));
    assign is_empty_s = (sp_q == '0);
    assign top_s      = stack_q[IDX_W'(sp_q - SP_W'(1))];
    assign elig_s     = pend_q & intr_mask;
    assign vec_s      = VEC_BASE + PC_W'(take_id_s) * PC_W'(VEC_STRIDE);

    // Only plain sequential or jump instructions may be diverted to a vector.
    assign take_s = intr_en && !in_svc_q && !is_full_s && (|elig_s) &&
                    !call && !reti && !pc_sel[1];

    // Lowest-numbered eligible line wins: scan downward so the last hit is lowest.
    always_comb begin
        take_id_s = '0;
        for (int i = N_INTR - 1; i >= 0; i--) begin
            if (elig_s[i]) begin
                take_id_s = ID_W'(i);
            end else begin
                take_id_s = take_id_s;
            end
        end
    end

    // Next-state selection for PC, stack pointer, interrupt and error state.
    always_comb begin
        pc_d       = pc_q;
        sp_d       = sp_q;
        push_s     = 1'b0;
        push_val_s = pc_inc_s;
        in_svc_d   = in_svc_q;
        id_d       = id_q;
        pend_d     = pend_q;
        ovf_d      = ovf_q & ~clr_err;
        udf_d      = udf_q & ~clr_err;
        if (call) begin
            pc_d = target;
            if (is_full_s) begin
                ovf_d = 1'b1;
            end else begin
                push_s = 1'b1;
                sp_d   = sp_q + SP_W'(1);
            end
        end else if (reti || (pc_sel == 2'b10)) begin
            if (is_empty_s) begin
                pc_d  = pc_inc_s;
                udf_d = 1'b1;
            end else begin
                pc_d = top_s;
                sp_d = sp_q - SP_W'(1);
            end
            if (reti) begin
                in_svc_d = 1'b0;
            end else begin
                in_svc_d = in_svc_q;
            end
        end else if (take_s) begin
            push_s     = 1'b1;
            push_val_s = pc_sel[0] ? target : pc_inc_s;
            sp_d       = sp_q + SP_W'(1);
            pc_d       = vec_s;
            pend_d     = pend_q & ~(N_INTR'(1) << take_id_s);
            in_svc_d   = 1'b1;
            id_d       = take_id_s;
        end else begin
            case (pc_sel)
                2'b00:   pc_d = pc_inc_s;
                2'b01:   pc_d = target;
                default: pc_d = pc_q;
            endcase
        end
        // New edges are merged after the clear so a re-rise on the taken line survives.
        pend_d = pend_d | (intr & ~prev_q);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= '0;
            sp_q     <= '0;
            prev_q   <= '1;
            pend_q   <= '0;
            in_svc_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            ack_q    <= 1'b0;
            id_q     <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            pc_q     <= pc_d;
            sp_q     <= sp_d;
            prev_q   <= intr;
            pend_q   <= pend_d;
            in_svc_q <= in_svc_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            ack_q    <= take_s;
            id_q     <= id_d;
            full_q   <= (sp_d == SP_W'(STACK_DEPTH));
            empty_q  <= (sp_d == '0);
        end
    end

    // Return-stack storage; contents beyond sp are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_q[IDX_W'(sp_q)] <= push_val_s;
        end
    end

    assign pc          = pc_q;
    assign stack_full  = full_q;
    assign stack_empty = empty_q;
    assign err_ovf     = ovf_q;
    assign err_udf     = udf_q;
    assign intr_ack    = ack_q;
    assign intr_id     = id_q;
    assign in_service  = in_svc_q;

endmodule

// File: tb/tb_seq_unit.sv
// Self-checking bench for seq_unit: directed scenarios plus random traffic,
// each cycle compared against a queue-based behavioural model.
module tb_seq_unit;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] pc_sel;
    logic [9:0] target;
    logic       call, reti;
    logic [7:0] intr, intr_mask;
    logic       intr_en, clr_err;
    logic [9:0] pc;
    logic       stack_full, stack_empty, err_ovf, err_udf, intr_ack, in_service;
    logic [2:0] intr_id;

    int n_pass  = 0;
    int n_total = 0;

    int         m_pc;
    int         m_stack [$];
    logic [7:0] m_pend, m_prev;
    bit         m_insvc, m_ovf, m_udf, m_ack;
    int         m_id;

    always #5 clk = ~clk;

    seq_unit dut (
        .clk        (clk),
        .reset      (reset),
        .pc_sel     (pc_sel),
        .target     (target),
        .call       (call),
        .reti       (reti),
        .intr       (intr),
        .intr_mask  (intr_mask),
        .intr_en    (intr_en),
        .clr_err    (clr_err),
        .pc         (pc),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .err_ovf    (err_ovf),
        .err_udf    (err_udf),
        .intr_ack   (intr_ack),
        .intr_id    (intr_id),
        .in_service (in_service)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Behavioural model: applies one clock edge with the inputs currently driven.
    task automatic model_update();
        int         nxt;
        int         k;
        logic [7:0] elig;
        bit         take;
        if (reset) begin
            m_pc = 0; m_stack.delete(); m_pend = 8'h00; m_prev = 8'hFF;
            m_insvc = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_ack = 1'b0; m_id = 0;
            return;
        end
        nxt  = (m_pc + 1) % 1024;
        elig = m_pend & intr_mask;
        take = intr_en && !m_insvc && (m_stack.size() < DEPTH) && (elig != 8'h00)
               && !call && !reti && (pc_sel == 2'b00 || pc_sel == 2'b01);
        if (clr_err) begin
            m_ovf = 1'b0; m_udf = 1'b0;
        end
        m_ack = take;
        if (call) begin
            if (m_stack.size() == DEPTH) m_ovf = 1'b1;
            else m_stack.push_back(nxt);
            m_pc = int'(target);
        end else if (reti || pc_sel == 2'b10) begin
            if (m_stack.size() == 0) begin
                m_udf = 1'b1;
                m_pc  = nxt;
            end else begin
                m_pc = m_stack.pop_back();
            end
            if (reti) m_insvc = 1'b0;
        end else if (take) begin
            k = 0;
            while (!elig[k]) k++;
            m_stack.push_back((pc_sel == 2'b01) ? int'(target) : nxt);
            m_pc    = (int'(10'h3F0) + k * 2) % 1024;
            m_pend[k] = 1'b0;
            m_insvc = 1'b1;
            m_id    = k;
        end else if (pc_sel == 2'b00) begin
            m_pc = nxt;
        end else if (pc_sel == 2'b01) begin
            m_pc = int'(target);
        end
        m_pend = m_pend | (intr & ~m_prev);
        m_prev = intr;
    endtask

    task automatic step(input string tag);
        model_update();
        @(posedge clk);
        #1;
        check({tag, ".pc"},         32'(pc),          32'(m_pc));
        check({tag, ".full"},       32'(stack_full),  32'(m_stack.size() == DEPTH));
        check({tag, ".empty"},      32'(stack_empty), 32'(m_stack.size() == 0));
        check({tag, ".err_ovf"},    32'(err_ovf),     32'(m_ovf));
        check({tag, ".err_udf"},    32'(err_udf),     32'(m_udf));
        check({tag, ".intr_ack"},   32'(intr_ack),    32'(m_ack));
        check({tag, ".intr_id"},    32'(intr_id),     32'(m_id));
        check({tag, ".in_service"}, 32'(in_service),  32'(m_insvc));
    endtask

    initial begin
        reset = 1'b1; pc_sel = 2'b00; target = 10'h000; call = 1'b0; reti = 1'b0;
        intr = 8'h00; intr_mask = 8'hFF; intr_en = 1'b1; clr_err = 1'b0;

        step("reset");
        check("rst_pc", 32'(pc), 32'(10'h000));
        check("rst_empty", 32'(stack_empty), 32'(1'b1));

        // Sequential wrap
        reset = 1'b0;
        for (int i = 1; i <= 1025; i++) begin
            step("wrap");
            if (i == 1023) check("wrap_3ff", 32'(pc), 32'(10'h3FF));
        end
        check("wrap_001", 32'(pc), 32'(10'h001));

        // Call / return
        reset = 1'b1; step("rst2"); reset = 1'b0;
        repeat (5) step("to5");
        check("at5", 32'(pc), 32'(10'h005));
        call = 1'b1; target = 10'h040; step("call");
        call = 1'b0;
        check("call_pc", 32'(pc), 32'(10'h040));
        pc_sel = 2'b10; step("ret");
        pc_sel = 2'b00;
        check("ret_pc", 32'(pc), 32'(10'h006));
        check("ret_empty", 32'(stack_empty), 32'(1'b1));

        // Overflow / underflow
        reset = 1'b1; step("rst3"); reset = 1'b0;
        for (int i = 0; i < 9; i++) begin
            call = 1'b1; target = 10'(10'h100 + i);
            step("ovf_call");
            if (i == 7) check("full8", 32'(stack_full), 32'(1'b1));
        end
        call = 1'b0;
        check("ovf9", 32'(err_ovf), 32'(1'b1));
        check("ovf_pc", 32'(pc), 32'(10'h108));
        pc_sel = 2'b10;
        for (int i = 0; i < 8; i++) begin
            step("pop");
            if (i == 0) check("pop_first", 32'(pc), 32'(10'h107));
        end
        check("pop_last", 32'(pc), 32'(10'h001));
        step("pop9");
        check("udf9", 32'(err_udf), 32'(1'b1));
        check("udf_pc", 32'(pc), 32'(10'h002));
        clr_err = 1'b1; step("clr_and_udf");
        check("udf_wins", 32'(err_udf), 32'(1'b1));
        check("ovf_cleared", 32'(err_ovf), 32'(1'b0));
        pc_sel = 2'b00; step("clr");
        clr_err = 1'b0;
        check("udf_cleared", 32'(err_udf), 32'(1'b0));

        // Interrupt priority
        reset = 1'b1; step("rst4"); reset = 1'b0;
        repeat (15) step("to00f");
        intr = 8'b0010_0100; step("prio_rise");
        check("prio_at010", 32'(pc), 32'(10'h010));
        step("prio_take");
        check("prio_vec", 32'(pc), 32'(10'h3F4));
        check("prio_id", 32'(intr_id), 32'(3'd2));
        check("prio_ack", 32'(intr_ack), 32'(1'b1));
        step("prio_svc");
        check("prio_ack_off", 32'(intr_ack), 32'(1'b0));
        reti = 1'b1; step("prio_reti"); reti = 1'b0;
        check("prio_ret", 32'(pc), 32'(10'h011));
        step("prio_take5");
        check("prio_vec5", 32'(pc), 32'(10'h3FA));
        check("prio_id5", 32'(intr_id), 32'(3'd5));
        reti = 1'b1; step("prio_reti5"); reti = 1'b0;

        // Masking and deferral
        intr = 8'h00; step("mask_low");
        intr_mask = 8'hF7; intr = 8'b0000_1000; step("mask_rise");
        repeat (3) step("masked");
        check("masked_no_take", 32'(in_service), 32'(1'b0));
        intr_mask = 8'hFF; step("unmask");
        check("unmask_take", 32'(in_service), 32'(1'b1));
        check("unmask_vec", 32'(pc), 32'(10'h3F6));
        reti = 1'b1; step("mask_reti"); reti = 1'b0;
        intr = 8'b0000_1010; step("defer_rise");
        call = 1'b1; target = 10'h050; step("defer_call"); call = 1'b0;
        check("defer_wait", 32'(in_service), 32'(1'b0));
        step("defer_take");
        check("defer_vec", 32'(pc), 32'(10'h3F2));
        reti = 1'b1; step("defer_reti"); reti = 1'b0;
        check("defer_ret", 32'(pc), 32'(10'h051));

        // Reset in the middle of a handler
        intr = 8'h00; step("mid_low");
        call = 1'b1; target = 10'h020; step("mid_call1");
        target = 10'h030; step("mid_call2"); call = 1'b0;
        intr = 8'h01; step("mid_rise");
        step("mid_take");
        check("mid_insvc", 32'(in_service), 32'(1'b1));
        reset = 1'b1; step("mid_reset"); reset = 1'b0;
        check("mid_rst_pc", 32'(pc), 32'(10'h000));
        check("mid_rst_empty", 32'(stack_empty), 32'(1'b1));
        repeat (3) step("held_high");
        check("held_no_take", 32'(in_service), 32'(1'b0));
        intr = 8'h00; step("held_fall");
        intr = 8'h01; step("held_rise");
        step("held_take");
        check("held_take_vec", 32'(pc), 32'(10'h3F0));

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            reset     = ($urandom_range(63) == 0);
            pc_sel    = 2'($urandom_range(3));
            target    = 10'($urandom);
            call      = ($urandom_range(7) == 0);
            reti      = ($urandom_range(7) == 0);
            if ($urandom_range(3) == 0) intr = 8'($urandom);
            intr_mask = ($urandom_range(3) == 0) ? 8'($urandom) : 8'hFF;
            intr_en   = ($urandom_range(7) != 0);
            clr_err   = ($urandom_range(15) == 0);
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_unit.md
SEQ_UNIT -- requirements
Module: seq_unit

Interface
REQ-001 Parameter PC_W, default 10: program-counter and return-address width.
REQ-002 Parameter STACK_DEPTH, default 8: return-stack entries (2..64).
REQ-003 Parameter N_INTR, default 8: interrupt request lines (1..16).
REQ-004 Parameter VEC_BASE, default 10'h3F0: address of interrupt vector 0.
REQ-005 Parameter VEC_STRIDE, default 2: address distance between consecutive vectors.
REQ-006 One clock; reset is synchronous and active-high. Ports are named clk and reset.
REQ-007 clk  input  1  rising-edge clock.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 pc_sel  input  2  next-PC source: 00 = PC+1, 01 = target, 10 = return (pop), 11 = hold.
REQ-010 target  input  PC_W  jump and call destination.
REQ-011 call  input  1  push PC+1 and go to target; overrides pc_sel.
REQ-012 reti  input  1  pop, clear in_service; overrides pc_sel; call has priority over reti.
REQ-013 intr  input  N_INTR  interrupt request lines, rising-edge sensitive.
REQ-014 intr_mask  input  N_INTR  per-line enable, 1 = enabled.
REQ-015 intr_en  input  1  global interrupt enable.
REQ-016 clr_err  input  1  clears the sticky error flags.
REQ-017 pc  output  PC_W  current program counter (registered).
REQ-018 stack_full / stack_empty  output  1 each  sp == STACK_DEPTH / sp == 0.
REQ-019 err_ovf / err_udf  output  1 each  sticky stack overflow / underflow.
REQ-020 intr_ack  output  1  one-cycle pulse in the cycle after an interrupt is taken.
REQ-021 intr_id  output  clog2(N_INTR) (min 1)  index of the last taken interrupt.
REQ-022 in_service  output  1  an interrupt handler is active.

Function
REQ-023 Next PC:
- 00: pc+1, wrapping modulo 2^PC_W (3FF -> 000).
- 01: target.
- 10: top of stack.
- 11: pc unchanged.
REQ-024 call: pushes pc+1 (wrapped) and loads target in the same edge.
REQ-025 pc_sel=10 or reti: loads the top entry and decrements sp.
REQ-026 Edge detection:
- per-line prev register; pending[i] set when intr[i]=1 and prev[i]=0;
- pending[i] stays set until taken, regardless of mask.
REQ-027 Interrupt take conditions, all required:
- intr_en=1, in_service=0, stack_full=0, (pending & intr_mask) != 0;
- call=0, reti=0, pc_sel in {00, 01}.
REQ-028 Priority: lowest index wins.
REQ-029 Take actions, in one edge:
- push the next PC the instruction would have produced;
- pc <= VEC_BASE + id*VEC_STRIDE (modulo 2^PC_W);
- pending[id] cleared, in_service <= 1, intr_id <= id, intr_ack = 1 for the following cycle.
REQ-030 No nesting: pending interrupts wait while in_service=1. A line pending in the same edge it is taken is not lost.
REQ-031 Overflow (push with stack_full=1):
- push suppressed, sp unchanged, err_ovf <= 1;
- PC still loads target.
REQ-032 Underflow (pop with stack_empty=1):
- pc <= pc+1, sp unchanged, err_udf <= 1;
- reti still clears in_service.
REQ-033 clr_err clears both error flags. A new error in the same cycle wins, so the flag stays set.
REQ-034 Pop returns the most recent push (LIFO). Stack contents outside valid depth are don't-care.

Reset
REQ-035 In the cycle after reset=1:
- pc=0, sp=0, pending=0, in_service=0;
- err_ovf=0, err_udf=0, intr_ack=0, intr_id=0.
REQ-036 prev resets to all-ones, so lines held high through reset do not pend.
REQ-037 Reset overrides every other input, including mid-call, mid-interrupt and an error cycle.

Verification
REQ-038 Sequential wrap: reset, pc_sel=00 for 1025 cycles -> pc runs 0..3FF, then 000, 001.
REQ-039 Call/return: at pc=005, call with target=040, then pc_sel=10 -> pc goes 040, then 006; stack_empty=1 after.
REQ-040 Overflow: 9 calls -> stack_full=1 after the 8th; err_ovf=1 after the 9th; 8 pops return correct LIFO addresses; a 9th pop sets err_udf=1.
REQ-041 Interrupt priority:
- stimulus: intr=8'b0010_0100 rises at pc=010 (intr_en=1, mask=FF, pc_sel=00);
- response: pc=3F4, intr_id=2, intr_ack pulse, stack top=011;
- reti -> pc=011, then line 5 is taken, pc=3FA.
REQ-042 Masking/deferral:
- mask[3]=0 with intr[3] rising -> no take;
- setting mask[3]=1 later -> taken;
- interrupt pending during call -> taken the next eligible cycle.
REQ-043 Reset mid-handler: in_service=1, sp=3, reset -> all outputs at reset values; intr held high gives no take until a new rising edge.
